mux81_rr_sched: RTL

- Round-robin scheduler that shares the 8-input, 8-bit select mux among 8 requesters.
- Drives the mux's 3-bit select and a one-hot grant vector.
- Presents a valid/ready stream downstream of the mux output and holds a grant for a packet or burst, bounded by a beat limit.
- Sits between the requester agents and the mux; the datapath itself stays outside this block.

---
 rtl/mux81_rr_sched_if.sv | 22 ++
 rtl/mux81_rr_sched.sv | 106 ++++++++++
 2 files changed

// File: rtl/mux81_rr_sched_if.sv
// Requester/downstream handshake bundle for the 8:1 mux round-robin scheduler.
// master = requester/downstream side, slave = scheduler.
interface mux81_rr_sched_if;
  logic [7:0] req;
  logic [7:0] last;
  logic       out_ready;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       out_valid;
  logic       abort;
  logic       busy;

  modport master (
    output req, last, out_ready,
    input  sel, gnt, out_valid, abort, busy
  );

  modport slave (
    input  req, last, out_ready,
    output sel, gnt, out_valid, abort, busy
  );
endinterface

// File: rtl/mux81_rr_sched.sv
// Round-robin scheduler for an 8-input select mux. Holds a grant for a packet
// or burst (capped at MAX_BURST beats), then always passes through one IDLE
// cycle before re-arbitrating. The datapath mux lives outside this block.
module mux81_rr_sched #(
  parameter int MAX_BURST = 4  // 1..255 beats per grant
) (
  input logic             clk,
  input logic             rst,
  mux81_rr_sched_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e     state_q, state_d;
  logic [2:0] sel_q,   sel_d;
  logic [2:0] ptr_q,   ptr_d;   // last released requester; scan starts at ptr+1
  logic [7:0] gnt_q,   gnt_d;
  logic [7:0] bcnt_q,  bcnt_d;  // beats moved in the current grant
  logic       abort_q, abort_d;

  logic [2:0] winner;
  logic       win_found;
  logic       xfer;

  // Rotating-priority search: first requester after ptr, wrapping mod 8.
  // The k=8 step lands back on ptr itself so it is considered last.
  always_comb begin
    winner    = ptr_q;
    win_found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!win_found && bus.req[ptr_q + 3'(k)]) begin
        winner    = ptr_q + 3'(k);
        win_found = 1'b1;
      end
    end
  end

  assign bus.out_valid = (state_q == GRANT) && bus.req[sel_q];
  assign xfer          = bus.out_valid && bus.out_ready;
  assign bus.busy      = (state_q == GRANT);
  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.abort     = abort_q;

  // Next-state: arbitrate in IDLE, count beats / release / abort in GRANT.
  // Dropping req while granted means out_valid is low, so no beat can move
  // that cycle; that is the abort condition.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    bcnt_d  = bcnt_q;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d = 8'h00;
        if (bus.req != 8'h00) begin
          sel_d   = winner;
          gnt_d   = 8'b1 << winner;
          bcnt_d  = 8'h00;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          bcnt_d = bcnt_q + 8'd1;
          if (bus.last[sel_q] || (bcnt_q == 8'(MAX_BURST - 1))) begin
            ptr_d   = sel_q;
            gnt_d   = 8'h00;
            state_d = IDLE;
          end
        end else if (!bus.req[sel_q]) begin
          abort_d = 1'b1;
          ptr_d   = sel_q;
          gnt_d   = 8'h00;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
      end
    endcase
  end

  // State and registered outputs; ptr=7 puts requester 0 first after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd7;
      gnt_q   <= 8'h00;
      bcnt_q  <= 8'h00;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      bcnt_q  <= bcnt_d;
      abort_q <= abort_d;
    end
  end

endmodule
